rx_frame_sync: RTL and testbench
================================

# rx_frame_sync

Receive-side frame synchronizer that sits directly downstream of the signal-detect stage and the PSK demodulator's hard-decision bit output. While `SD_flag` is high it searches the demodulated bit stream for a configurable sync word, tolerating a configurable number of bit errors. After a match it packs the following bits MSB-first into bytes and emits exactly one frame of `RX_FRAME_LEN` bytes. It aborts the frame cleanly when carrier (`SD_flag`) is lost.

## Interface
- `SYNC_WIDTH`, 32: sync word length in bits.
- `LEN_WIDTH`, 8: width of the frame-length configuration.
- `MAX_ERR_WIDTH`, 3: width of the error-tolerance configuration.
- `clk`  in  1  system clock, 16.384 MHz; the only clock.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `RX_SYNC_WORD`  in  SYNC_WIDTH  sync pattern; the MSB is received first.
- `RX_SYNC_MAX_ERR`  in  MAX_ERR_WIDTH  maximum Hamming distance still accepted as a match.
- `RX_FRAME_LEN`  in  LEN_WIDTH  payload bytes per frame; 0 means 2^LEN_WIDTH.
- `SD_flag`  in  1  signal-detect flag from the upstream stage.
- `bit_tdata`  in  1  demodulated hard bit.
- `bit_tvalid`  in  1  `bit_tdata` is valid this cycle. At most one bit per cycle; no backpressure.
- `byte_tdata`  out  8  payload byte; the first received bit is bit 7.
- `byte_tvalid`  out  1  one-cycle strobe per byte.
- `byte_tlast`  out  1  high together with `byte_tvalid` on the last byte of a frame.
- `frame_start`  out  1  one-cycle pulse when a sync match is accepted.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high while the block is in PAYLOAD.

## Operation
- States: IDLE, SEARCH, PAYLOAD.
- **IDLE**
  - Shift register, fill counter, bit counter and byte counter are held at 0.
  - Goes to SEARCH when `SD_flag` = 1.
- **SEARCH**
  - On each `bit_tvalid`: `sr <= {sr[SYNC_WIDTH-2:0], bit_tdata}`; the fill counter increments and saturates at SYNC_WIDTH.
  - Match test is combinational on the updated value: `popcount({sr[SYNC_WIDTH-2:0], bit_tdata} ^ RX_SYNC_WORD) <= RX_SYNC_MAX_ERR`.
  - The test is qualified by `bit_tvalid` and by fill count reaching SYNC_WIDTH including the current bit. No match is possible before SYNC_WIDTH bits have been received.
  - On a match:
    - go to PAYLOAD;
    - latch `RX_FRAME_LEN` (0 maps to 2^LEN_WIDTH), so configuration changes mid-frame have no effect;
    - clear the bit and byte counters;
    - pulse `frame_start`.
  - `SD_flag` = 0 takes the block to IDLE with no pulse.
- **PAYLOAD**
  - On each `bit_tvalid`, the bit shifts into the byte register MSB-first and the bit counter increments mod 8.
  - On the 8th bit the byte is output and the byte counter increments.
  - The byte whose count equals the latched length also asserts `byte_tlast`. The block then returns to SEARCH with the shift register and fill counter cleared; the payload bits are never reused for matching.
  - `SD_flag` = 0 in PAYLOAD:
    - pulse `frame_err` and go to IDLE;
    - the partial byte is discarded and no `byte_tvalid` is produced;
    - abort has priority over a simultaneous `bit_tvalid`, including one that would have completed the final byte.
- Popcount result width is `$clog2(SYNC_WIDTH+1)`. `RX_SYNC_MAX_ERR` is zero-extended before the compare.
- Reset, asynchronous with `rst` = 0:
  - state IDLE;
  - all counters and registers 0;
  - `byte_tdata` = 0 and every output strobe 0; `busy` = 0.

## Timing
- All outputs are registered.
- `frame_start` is high in the cycle after the `bit_tvalid` cycle that completes the sync word. `busy` rises in that same cycle.
- `byte_tvalid`, `byte_tdata` and `byte_tlast` are valid in the cycle after the 8th bit's `bit_tvalid` cycle. `byte_tdata` holds its value until the next byte.
- `busy` falls in the same cycle that the final `byte_tvalid` / `byte_tlast` appears.
- `frame_err` is high in the cycle after the first cycle in which `SD_flag` = 0 in PAYLOAD.
- Back-to-back `bit_tvalid` is supported. A bit arriving in the cycle after the final payload bit is processed in SEARCH.
- Reset assertion is asynchronous. Deassertion is synchronized externally; the first valid bit is sampled on the first clock edge after deassertion.

## Test plan
- **Exact match.** Word 0x1ACFFC1D, max_err 0, len 2, `SD_flag` = 1; stream 8 noise bits, the sync word, 0xA5, 0x3C, all bits valid in consecutive cycles. Expect:
  - `frame_start` 1 cycle after the last sync bit;
  - bytes 0xA5 then 0x3C, 8 cycles apart, `byte_tlast` only on 0x3C;
  - `busy` low afterwards.
- **Error tolerance.** Same stream with 2 sync bits flipped. With max_err 2 the frame is received identically; with max_err 1 there is no `frame_start` and no bytes.
- **Carrier loss.** Drop `SD_flag` after 12 payload bits of a len-4 frame. Expect:
  - exactly one byte out;
  - `frame_err` for 1 cycle;
  - `busy` = 0, state IDLE;
  - re-asserting `SD_flag` and resending the sync word gives a new `frame_start`.
- **Priority and gaps.**
  - `SD_flag` falls in the same cycle as the final payload bit: no `byte_tvalid` / `byte_tlast`, `frame_err` pulses.
  - Separately, `bit_tvalid` toggling 1-of-3 cycles yields the same bytes as the gap-free case.
- **Length 0 and fill guard.** len 0 yields 256 bytes with `byte_tlast` on the 256th. A sync word embedded in the first 31 bits after SEARCH entry (fewer than SYNC_WIDTH bits) never matches.
- **Reset mid-frame.** Assert `rst` = 0 mid-PAYLOAD with no clock edge. All outputs go 0 immediately; after release, 0xA5 sent without a sync word produces no output.

Source files
------------

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: error-tolerant sync word search, then MSB-first byte packing of one fixed-length frame.
module rx_frame_sync #(
   parameter int SYNC_WIDTH    = 32,
   parameter int LEN_WIDTH     = 8,
   parameter int MAX_ERR_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SYNC_WIDTH-1:0]    RX_SYNC_WORD,
   input  logic [MAX_ERR_WIDTH-1:0] RX_SYNC_MAX_ERR,
   input  logic [LEN_WIDTH-1:0]     RX_FRAME_LEN,
   input  logic                     SD_flag,
   input  logic                     bit_tdata,
   input  logic                     bit_tvalid,
   output logic [7:0]               byte_tdata,
   output logic                     byte_tvalid,
   output logic                     byte_tlast,
   output logic                     frame_start,
   output logic                     frame_err,
   output logic                     busy
);
   localparam int CW = $clog2(SYNC_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SEARCH, PAYLOAD} state_t;
   state_t                state, state_n;
   logic [SYNC_WIDTH-2:0] sr;
   logic [SYNC_WIDTH-1:0] sr_n;
   logic [CW-1:0]         fill, err;
   logic [2:0]            bit_cnt;
   logic [LEN_WIDTH:0]    byte_cnt, len_q;
   logic [6:0]            byte_reg;
   logic                  match, byte_done, last, abort;

   assign sr_n = {sr, bit_tdata};
   assign busy = state == PAYLOAD;

   always_comb begin
      err = '0;
      for (int i = 0; i < SYNC_WIDTH; i++) err = err + CW'(sr_n[i] ^ RX_SYNC_WORD[i]);
      match     = state == SEARCH && SD_flag && bit_tvalid && fill >= CW'(SYNC_WIDTH - 1) &&
                  32'(err) <= 32'(RX_SYNC_MAX_ERR);
      byte_done = state == PAYLOAD && SD_flag && bit_tvalid && bit_cnt == 3'd7;
      last      = byte_done && byte_cnt + 1'b1 == len_q;
      abort     = state == PAYLOAD && !SD_flag;
      state_n   = state == IDLE ? (SD_flag ? SEARCH : IDLE) :
                  !SD_flag ? IDLE : match ? PAYLOAD : last ? SEARCH : state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sr          <= '0;
         fill        <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         len_q       <= '0;
         byte_reg    <= '0;
         byte_tdata  <= '0;
         byte_tvalid <= 1'b0;
         byte_tlast  <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_n;
         frame_start <= match;
         frame_err   <= abort;
         byte_tvalid <= byte_done;
         byte_tlast  <= last;
         if (byte_done) byte_tdata <= {byte_reg, bit_tdata};
         if (state != SEARCH || state_n != SEARCH) begin
            sr   <= '0;
            fill <= '0;
         end else if (bit_tvalid) begin
            sr   <= sr_n[SYNC_WIDTH-2:0];
            fill <= fill == CW'(SYNC_WIDTH) ? fill : fill + 1'b1;
         end
         if (match) len_q <= RX_FRAME_LEN == '0 ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, RX_FRAME_LEN};
         if (state != PAYLOAD) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end else if (SD_flag && bit_tvalid) begin
            bit_cnt  <= bit_cnt + 1'b1;
            byte_reg <= {byte_reg[5:0], bit_tdata};
            if (byte_done) byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: table vectors, corner sequences and random traffic against a queue-based reference model.
module tb_rx_frame_sync;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] word = 32'h1ACFFC1D;
   logic [2:0]  maxerr = 3'd0;
   logic [7:0]  len = 8'd2;
   logic        sd = 1'b0, v = 1'b0, b = 1'b0;
   logic [7:0]  byte_tdata;
   logic        byte_tvalid, byte_tlast, frame_start, frame_err, busy;
   logic [4:0]  o;

   rx_frame_sync dut (
      .clk(clk), .rst(rst), .RX_SYNC_WORD(word), .RX_SYNC_MAX_ERR(maxerr), .RX_FRAME_LEN(len),
      .SD_flag(sd), .bit_tdata(b), .bit_tvalid(v), .byte_tdata(byte_tdata), .byte_tvalid(byte_tvalid),
      .byte_tlast(byte_tlast), .frame_start(frame_start), .frame_err(frame_err), .busy(busy)
   );

   assign o = {frame_start, frame_err, byte_tvalid, byte_tlast, busy};
   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int n_fs, n_fe, n_bv, n_bl, bl_at;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: bits since hunting began kept in a queue, payload bits collected until 8
   int         m_mode, m_nb, m_len;
   bit         hist[$], pay[$];
   logic [4:0] m_out;
   logic [7:0] m_data;

   task automatic mreset();
      m_mode = 0; m_nb = 0; m_len = 0;
      hist.delete(); pay.delete();
      m_out = '0; m_data = '0;
   endtask

   task automatic mstep(input logic s, input logic vv, input logic bb);
      logic fs, fe, bv, bl;
      logic [31:0] w;
      fs = 0; fe = 0; bv = 0; bl = 0;
      if (m_mode == 0) begin
         if (s) begin m_mode = 1; hist.delete(); end
      end else if (!s) begin
         fe = m_mode == 2;
         m_mode = 0;
      end else if (vv && m_mode == 1) begin
         hist.push_back(bb);
         if (hist.size() > 32) void'(hist.pop_front());
         if (hist.size() == 32) begin
            w = '0;
            foreach (hist[i]) w = {w[30:0], hist[i]};
            if ($countones(w ^ word) <= int'(maxerr)) begin
               fs = 1; m_mode = 2; m_nb = 0; pay.delete();
               m_len = len == 0 ? 256 : int'(len);
            end
         end
      end else if (vv && m_mode == 2) begin
         pay.push_back(bb);
         if (pay.size() == 8) begin
            m_data = '0;
            foreach (pay[i]) m_data = {m_data[6:0], pay[i]};
            pay.delete();
            bv = 1; m_nb++;
            if (m_nb == m_len) begin bl = 1; m_mode = 1; hist.delete(); end
         end
      end
      m_out = {fs, fe, bv, bl, m_mode == 2};
   endtask

   task automatic clr();
      n_fs = 0; n_fe = 0; n_bv = 0; n_bl = 0; bl_at = 0;
   endtask

   task automatic step(input logic s, input logic vv, input logic bb);
      sd = s; v = vv; b = bb;
      mstep(s, vv, bb);
      @(posedge clk); #1;
      chk("model_outs", o, m_out);
      chk("model_data", byte_tdata, m_data);
      n_fs += int'(frame_start); n_fe += int'(frame_err); n_bv += int'(byte_tvalid);
      if (byte_tlast) begin n_bl++; bl_at = n_bv; end
   endtask

   task automatic send(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, val[i]);
   endtask

   typedef struct {
      logic       sd;
      logic       v;
      logic       b;
      logic [4:0] exp;
      logic [7:0] d;
   } vec_t;
   vec_t tbl[$];

   task automatic push(input logic s, input logic vv, input logic bb, input logic [4:0] e, input logic [7:0] dd);
      vec_t x;
      x.sd = s; x.v = vv; x.b = bb; x.exp = e; x.d = dd;
      tbl.push_back(x);
   endtask

   // 8 noise bits, sync, 0xA5, 0x3C; expectations written from the frame layout, gap idle cycles per bit
   task automatic build(input logic [31:0] sent, input bit ok, input int gap);
      logic [55:0] st;
      logic bsy, fs, bv, bl;
      st = {8'h5A, sent, 8'hA5, 8'h3C};
      bsy = 0;
      tbl.delete();
      push(1, 0, 0, 5'b0, 8'h0);
      for (int i = 0; i < 56; i++) begin
         fs = ok && i == 39;
         bv = ok && (i == 47 || i == 55);
         bl = ok && i == 55;
         if (fs) bsy = 1;
         if (i == 55) bsy = 0;
         push(1, 1, st[55-i], {fs, 1'b0, bv, bl, bsy}, i == 47 ? 8'hA5 : 8'h3C);
         repeat (gap) push(1, 0, 0, {4'b0, bsy}, 8'h0);
      end
      push(0, 0, 0, 5'b0, 8'h0);
   endtask

   task automatic run_table(input string nm);
      foreach (tbl[i]) begin
         sd = tbl[i].sd; v = tbl[i].v; b = tbl[i].b;
         mstep(tbl[i].sd, tbl[i].v, tbl[i].b);
         @(posedge clk); #1;
         chk({nm, "_outs"}, o, tbl[i].exp);
         if (tbl[i].exp[2]) chk({nm, "_data"}, byte_tdata, tbl[i].d);
      end
   endtask

   initial begin
      bit pend[$];
      logic [31:0] tmp;
      logic s, vv, bb;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {o, byte_tdata}, 0);
      rst = 1'b1;

      build(word, 1, 0);                     run_table("exact");
      maxerr = 3'd2; build(word ^ 32'h0001_0200, 1, 0); run_table("err2_ok");
      maxerr = 3'd1; build(word ^ 32'h0001_0200, 0, 0); run_table("err2_rej");
      maxerr = 3'd0; build(word, 1, 2);      run_table("gaps");

      len = 8'd4; clr();
      step(1, 0, 0); send(word, 32); send(32'hA53, 12); step(0, 0, 0);
      chk("loss_bytes", n_bv, 1);
      chk("loss_err", n_fe, 1);
      chk("loss_busy", busy, 0);
      step(0, 0, 0);
      chk("loss_err_once", n_fe, 1);
      step(1, 0, 0); send(word, 32);
      chk("loss_restart", n_fs, 2);
      step(0, 0, 0);

      len = 8'd1; clr();
      step(1, 0, 0); send(word, 32); send(32'h2D, 7); step(0, 1, 0);
      chk("prio_bytes", n_bv, 0);
      chk("prio_last", n_bl, 0);
      chk("prio_err", n_fe, 1);
      step(0, 0, 0);

      clr();
      step(1, 0, 0); send(word, 31);
      chk("fill_guard", n_fs, 0);
      send(32'h1, 1); step(0, 0, 0);
      chk("fill_guard2", n_fs, 0);

      len = 8'd0; clr();
      step(1, 0, 0); send(word, 32);
      for (int i = 0; i < 256; i++) send($urandom_range(0, 255), 8);
      chk("len0_bytes", n_bv, 256);
      chk("len0_last_cnt", n_bl, 1);
      chk("len0_last_at", bl_at, 256);
      chk("len0_busy", busy, 0);
      step(0, 0, 0);

      word = $urandom(); len = 8'd3;
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            maxerr = 3'($urandom_range(0, 3));
            len = 8'($urandom_range(1, 6));
         end
         if (pend.size() == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               tmp = word;
               repeat ($urandom_range(0, 3)) tmp[$urandom_range(0, 31)] ^= 1'b1;
               for (int i = 31; i >= 0; i--) pend.push_back(tmp[i]);
            end else repeat (8) pend.push_back(1'($urandom_range(0, 1)));
         end
         s = $urandom_range(0, 249) != 0;
         vv = $urandom_range(0, 3) != 0;
         bb = 1'b0;
         if (vv) bb = pend.pop_front();
         step(s, vv, bb);
      end
      step(0, 0, 0);

      word = 32'h1ACFFC1D; maxerr = 3'd0; len = 8'd2; clr();
      step(1, 0, 0); send(word, 32); send(32'hA, 4);
      #2 rst = 1'b0;
      #1 chk("async_reset", {o, byte_tdata}, 0);
      mreset();
      @(posedge clk); #1;
      rst = 1'b1; clr();
      step(1, 0, 0); send(32'hA5, 8);
      chk("post_reset_bytes", n_bv, 0);
      chk("post_reset_start", n_fs, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
